ads_slave_port: RTL

- Serial responder at the slave end of the ADS single-wire-per-direction bus.
- Receives a command frame on `rx` (bit-serial, one bit per clock, driven through the address decoder).
- Performs a write or read on an internal register file, then returns a response frame on `tx`.
- Drop-in slave for the bus top level. Adds a back-pressure input and parameterised storage depth.

---
 rtl/ads_pkg.sv | 30 +++
 rtl/ads_shift_tx.sv | 42 ++++
 rtl/ads_slave_port.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ads_pkg.sv
// Shared definitions for the ADS serial bus: slave FSM states, frame
// field encodings, line levels and default field widths.
package ads_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_MODE  = 3'd1,
    ST_RX_ADDR  = 3'd2,
    ST_RX_DATA  = 3'd3,
    ST_EXEC     = 3'd4,
    ST_WAIT     = 3'd5,
    ST_TX_START = 3'd6,
    ST_TX_BITS  = 3'd7
  } ads_state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int ADS_ADDR_W = 12;
  localparam int ADS_DATA_W = 8;

  // Bit-counter width able to hold the longest field length without wrapping.
  function automatic int ads_cnt_w(input int addr_w, input int data_w);
    return $clog2(((addr_w > data_w) ? addr_w : data_w) + 1);
  endfunction

endpackage

// File: rtl/ads_shift_tx.sv
// Loadable parallel-in/serial-out shifter for the response path.
// Emits load_len bits MSB first; last flags the final pending bit and
// done indicates nothing remains to send.
module ads_shift_tx
  import ads_pkg::*;
#(
  parameter int DATA_W = ADS_DATA_W,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CW-1:0]     load_len,
  input  logic              shift,
  output logic              sout,
  output logic              last,
  output logic              done
);

  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     left;

  // Load a new response word or advance one bit toward the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      left <= '0;
    end else if (load) begin
      sr   <= load_data;
      left <= load_len;
    end else if (shift && (left != '0)) begin
      sr   <= {sr[DATA_W-2:0], 1'b0};
      left <= left - 1'b1;
    end
  end

  assign sout = sr[DATA_W-1];
  assign last = (left == CW'(1));
  assign done = (left == '0);

endmodule

// File: rtl/ads_slave_port.sv
// ADS bus slave: deserialises a command frame from rx, performs a read or
// write on the local register file, and serialises the response on tx.
// A busy input holds the response in WAIT until the master can take it.
module ads_slave_port
  import ads_pkg::*;
#(
  parameter int ADDR_W = ADS_ADDR_W,
  parameter int DATA_W = ADS_DATA_W,
  parameter int DEPTH  = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic busy,
  output logic tx,
  output logic frame_done,
  output logic wr_strobe
);

  localparam int CW = ads_cnt_w(ADDR_W, DATA_W);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  ads_state_e        state;
  logic [CW-1:0]     cnt;
  logic              mode;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [AW-1:0]     mem_idx;
  logic              exec_wr;
  logic              piso_load;
  logic              piso_shift;
  logic [DATA_W-1:0] piso_data;
  logic [CW-1:0]     piso_len;
  logic              piso_sout;
  logic              piso_last;
  logic              piso_done;

  // Address decode and response word selection for the EXEC cycle.
  always_comb begin
    in_range   = ({1'b0, addr_sr} < DEPTH_L);
    mem_idx    = addr_sr[AW-1:0];
    exec_wr    = (state == ST_EXEC) && (mode == MODE_WRITE) && in_range;
    piso_load  = (state == ST_EXEC);
    piso_shift = (state == ST_TX_START) || ((state == ST_TX_BITS) && !piso_done);
    piso_data  = '0;
    piso_len   = CW'(DATA_W);
    if (mode == MODE_WRITE) begin
      // Write response is a single ack bit, placed at the MSB so it leaves first.
      piso_data = {in_range, {(DATA_W-1){1'b0}}};
      piso_len  = CW'(1);
    end else if (in_range) begin
      piso_data = mem[mem_idx];
    end
  end

  // Register file write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (exec_wr) begin
      mem[mem_idx] <= data_sr;
    end
  end

  // Frame sequencer with registered line and strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode       <= MODE_READ;
      addr_sr    <= '0;
      data_sr    <= '0;
      tx         <= IDLE_LEVEL;
      frame_done <= 1'b0;
      wr_strobe  <= 1'b0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx == START_BIT) state <= ST_RX_MODE;
        end
        ST_RX_MODE: begin
          mode  <= rx;
          cnt   <= '0;
          state <= ST_RX_ADDR;
        end
        ST_RX_ADDR: begin
          addr_sr <= {addr_sr[ADDR_W-2:0], rx};
          if (cnt == CW'(ADDR_W - 1)) begin
            cnt   <= '0;
            state <= (mode == MODE_WRITE) ? ST_RX_DATA : ST_EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RX_DATA: begin
          data_sr <= {data_sr[DATA_W-2:0], rx};
          if (cnt == CW'(DATA_W - 1)) begin
            cnt   <= '0;
            state <= ST_EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_EXEC: begin
          wr_strobe <= exec_wr;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!busy) begin
            tx    <= START_BIT;
            state <= ST_TX_START;
          end
        end
        ST_TX_START: begin
          tx         <= piso_sout;
          frame_done <= piso_last;
          state      <= ST_TX_BITS;
        end
        ST_TX_BITS: begin
          if (piso_done) begin
            tx    <= IDLE_LEVEL;
            state <= ST_IDLE;
          end else begin
            tx         <= piso_sout;
            frame_done <= piso_last;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ads_shift_tx #(
    .DATA_W (DATA_W),
    .CW     (CW)
  ) u_shift_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (piso_load),
    .load_data (piso_data),
    .load_len  (piso_len),
    .shift     (piso_shift),
    .sout      (piso_sout),
    .last      (piso_last),
    .done      (piso_done)
  );

endmodule
